// File: rtl/vector_fma_writeback_unit.sv
// vector_fma_writeback_unit
// Buffers FMA results in a small FIFO and drains them to the vector register
// file write port as valid/ready beats. Widening results produce two beats:
// vd to vd_addr, then vd_high to vd_addr+1 (wrapping).
// Optional feature macro: FMA_WB_ALIGN_CHECK_EN. When it is defined, widening
// results with an odd vd_addr are accepted but dropped, and wb_misaligned pulses.
module vector_fma_writeback_unit #(
  parameter int VLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int VADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               result_valid,
  output logic               result_ready,
  input  logic [VLEN-1:0]    vd,
  input  logic [VLEN-1:0]    vd_high,
  input  logic [VADDR_W-1:0] vd_addr,
  input  logic               widening,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [VADDR_W-1:0] wb_addr,
  output logic [VLEN-1:0]    wb_data,
  output logic               wb_last,
  output logic               busy
`ifdef FMA_WB_ALIGN_CHECK_EN
  ,
  output logic               wb_misaligned
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t state_reg, state_next;

  // Entry storage; the head entry stays in the FIFO until its last beat is taken.
  logic [VLEN-1:0]    mem_vd   [DEPTH];
  logic [VLEN-1:0]    mem_hi   [DEPTH];
  logic [VADDR_W-1:0] mem_addr [DEPTH];
  logic               mem_wide [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CNT_W-1:0] count_reg;
  logic             full, offer, push, pop;

  logic               wb_valid_reg, wb_valid_next;
  logic [VADDR_W-1:0] wb_addr_reg, wb_addr_next;
  logic [VLEN-1:0]    wb_data_reg, wb_data_next;
  logic               wb_last_reg, wb_last_next;
  logic               has_next;

  assign full         = (count_reg == CNT_W'(DEPTH));
  assign result_ready = reset_n && !full;
  assign offer        = result_valid && result_ready;
  assign rd_ptr_inc   = rd_ptr_reg + PTR_W'(1);
  // Another entry sits behind the head, so the next beat can follow without a bubble.
  assign has_next     = (count_reg > CNT_W'(1));

`ifdef FMA_WB_ALIGN_CHECK_EN
  logic misaligned, misaligned_reg;
  // Odd-based widening results complete the handshake but never enter the FIFO.
  assign misaligned    = offer && widening && vd_addr[0];
  assign push          = offer && !misaligned;
  assign wb_misaligned = misaligned_reg;

  // One-cycle flag following each dropped misaligned result.
  always_ff @(posedge clock) begin
    if (!reset_n) misaligned_reg <= 1'b0;
    else          misaligned_reg <= misaligned;
  end
`else
  assign push = offer;
`endif

  assign wb_valid = wb_valid_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;
  assign wb_last  = wb_last_reg;
  assign busy     = (count_reg != '0) || wb_valid_reg;

  // Write incoming results into the slot at the write pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_vd[wr_ptr_reg]   <= vd;
      mem_hi[wr_ptr_reg]   <= vd_high;
      mem_addr[wr_ptr_reg] <= vd_addr;
      mem_wide[wr_ptr_reg] <= widening;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: a beat advances only on wb_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (count_reg != '0) state_next = LOW;
      LOW: begin
        if (wb_ready) begin
          if (mem_wide[rd_ptr_reg]) state_next = HIGH;
          else if (has_next)        state_next = LOW;
          else                      state_next = IDLE;
        end
      end
      HIGH: begin
        if (wb_ready) state_next = has_next ? LOW : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the beat registers and the FIFO pop strobe.
  always_comb begin
    pop           = 1'b0;
    wb_valid_next = wb_valid_reg;
    wb_addr_next  = wb_addr_reg;
    wb_data_next  = wb_data_reg;
    wb_last_next  = wb_last_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          wb_valid_next = 1'b1;
          wb_addr_next  = mem_addr[rd_ptr_reg];
          wb_data_next  = mem_vd[rd_ptr_reg];
          wb_last_next  = !mem_wide[rd_ptr_reg];
        end
      end
      LOW, HIGH: begin
        if (wb_ready) begin
          if (state_reg == LOW && mem_wide[rd_ptr_reg]) begin
            wb_addr_next = mem_addr[rd_ptr_reg] + VADDR_W'(1);
            wb_data_next = mem_hi[rd_ptr_reg];
            wb_last_next = 1'b1;
          end else begin
            pop = 1'b1;
            if (has_next) begin
              wb_addr_next = mem_addr[rd_ptr_inc];
              wb_data_next = mem_vd[rd_ptr_inc];
              wb_last_next = !mem_wide[rd_ptr_inc];
            end else begin
              wb_valid_next = 1'b0;
            end
          end
        end
      end
      default: begin
        wb_valid_next = 1'b0;
      end
    endcase
  end

  // Registered beat outputs; held while stalled because the next values default to current.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      wb_last_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      wb_addr_reg  <= wb_addr_next;
      wb_data_reg  <= wb_data_next;
      wb_last_reg  <= wb_last_next;
    end
  end

endmodule
